// File: rtl/max_pool_stream.sv
// Streaming KxK non-overlapping max/average pooling over a raster-ordered pixel stream.
// Define POOL_AVG_EN to enable average mode; without it mode_avg is ignored (max only).
module max_pool_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CH_IN      = 3,
    parameter int unsigned IMG_W      = 4,
    parameter int unsigned IMG_H      = 4,
    parameter int unsigned POOL_SIZE  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode_avg,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [CH_IN*DATA_WIDTH-1:0] s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [CH_IN*DATA_WIDTH-1:0] m_data,
    output logic                        m_last,
    output logic                        busy
);
    localparam int unsigned LOG2K = (POOL_SIZE == 4) ? 2 : 1;
    localparam int unsigned OUT_W = (IMG_W + POOL_SIZE - 1) / POOL_SIZE;
`ifdef POOL_AVG_EN
    localparam int unsigned ACC_W = DATA_WIDTH + 2 * LOG2K;
`else
    localparam int unsigned ACC_W = DATA_WIDTH;
`endif
    // Counters carry two spare bits so the low LOG2K bits always exist.
    localparam int unsigned CW = $clog2(IMG_W) + 2;
    localparam int unsigned RW = $clog2(IMG_H) + 2;
    localparam int unsigned BW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                      state_q, state_d;
    logic [CW-1:0]               col_q;
    logic [RW-1:0]               row_q;
    logic                        m_valid_q, m_last_q;
    logic [CH_IN*DATA_WIDTH-1:0] m_data_q;
    logic [ACC_W-1:0]            lb_q [OUT_W][CH_IN];

    logic                        accept, col_end, row_end, win_start, win_done;
    logic [BW-1:0]               bin;
    logic [ACC_W-1:0]            pix     [CH_IN];
    logic [ACC_W-1:0]            acc_new [CH_IN];
    logic [CH_IN*DATA_WIDTH-1:0] result;

`ifdef POOL_AVG_EN
    logic mode_q, eff_avg;
    // The first beat of a frame is consumed in IDLE, before mode_q has been latched.
    assign eff_avg = (state_q == StIdle) ? mode_avg : mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (accept && state_q == StIdle) begin
            mode_q <= mode_avg;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode_avg;
`endif

    assign s_ready   = (!m_valid_q || m_ready) && (state_q != StDrain);
    assign accept    = s_valid && s_ready;
    assign col_end   = (col_q == CW'(IMG_W - 1));
    assign row_end   = (row_q == RW'(IMG_H - 1));
    assign win_start = (row_q[LOG2K-1:0] == '0) && (col_q[LOG2K-1:0] == '0);
    assign win_done  = ((row_q[LOG2K-1:0] == {LOG2K{1'b1}}) || row_end) &&
                       ((col_q[LOG2K-1:0] == {LOG2K{1'b1}}) || col_end);
    assign bin       = BW'(col_q >> LOG2K);

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign busy    = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = (col_end && row_end) ? StDrain : StRun;
            StRun:   if (accept && col_end && row_end) state_d = StDrain;
            StDrain: if (m_valid_q && m_ready && m_last_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        result = '0;
        for (int c = 0; c < CH_IN; c++) begin
            pix[c]     = ACC_W'(s_data[c*DATA_WIDTH +: DATA_WIDTH]);
            acc_new[c] = pix[c];
            if (!win_start) begin
`ifdef POOL_AVG_EN
                if (eff_avg) acc_new[c] = lb_q[bin][c] + pix[c];
                else if (lb_q[bin][c] > pix[c]) acc_new[c] = lb_q[bin][c];
`else
                if (lb_q[bin][c] > pix[c]) acc_new[c] = lb_q[bin][c];
`endif
            end
`ifdef POOL_AVG_EN
            // Edge windows still divide by K*K: missing pixels count as zero.
            result[c*DATA_WIDTH +: DATA_WIDTH] = eff_avg ?
                DATA_WIDTH'(acc_new[c] >> (2 * LOG2K)) : acc_new[c][DATA_WIDTH-1:0];
`else
            result[c*DATA_WIDTH +: DATA_WIDTH] = acc_new[c];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            col_q     <= '0;
            row_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (col_end) begin
                    col_q <= '0;
                    row_q <= row_end ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            if (accept && win_done) begin
                m_valid_q <= 1'b1;
                m_data_q  <= result;
                m_last_q  <= col_end && row_end;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
        end
    end

    // Partial sums are never reset; a window start always overwrites its entry.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < CH_IN; c++) lb_q[bin][c] <= acc_new[c];
        end
    end

endmodule

// File: tb/tb_max_pool_stream.sv
// Bench for max_pool_stream: a 4x4 and a 5x5 instance share stimulus, selected by sel.
`timescale 1ns/1ps
module tb_max_pool_stream;
    localparam int DW = 8;
    localparam int CH = 3;
    localparam int K  = 2;

    logic clk = 1'b0, rst = 1'b1, mode_avg = 1'b0, s_valid = 1'b0, m_ready = 1'b0, sel = 1'b0;
    logic [CH*DW-1:0] s_data = '0;
    logic s_ready, m_valid, m_last, busy;
    logic [CH*DW-1:0] m_data;
    logic sv_a, sv_b, rdy_a, rdy_b, mv_a, mv_b, ml_a, ml_b, busy_a, busy_b;
    logic [CH*DW-1:0] md_a, md_b;

    int n_tests = 0;
    int n_fail  = 0;
    int fr [25][CH];
    logic [CH*DW-1:0] exp_q [$];
    logic [CH*DW-1:0] got_q [$];
    logic             got_last_q [$];

    always #5 clk = ~clk;

    assign sv_a    = s_valid && !sel;
    assign sv_b    = s_valid && sel;
    assign s_ready = sel ? rdy_b : rdy_a;
    assign m_valid = sel ? mv_b : mv_a;
    assign m_data  = sel ? md_b : md_a;
    assign m_last  = sel ? ml_b : ml_a;
    assign busy    = sel ? busy_b : busy_a;

    max_pool_stream #(.DATA_WIDTH(DW), .CH_IN(CH), .IMG_W(4), .IMG_H(4), .POOL_SIZE(K)) dut_a (
        .clk(clk), .rst(rst), .mode_avg(mode_avg), .s_valid(sv_a), .s_ready(rdy_a),
        .s_data(s_data), .m_valid(mv_a), .m_ready(m_ready), .m_data(md_a), .m_last(ml_a),
        .busy(busy_a)
    );

    max_pool_stream #(.DATA_WIDTH(DW), .CH_IN(CH), .IMG_W(5), .IMG_H(5), .POOL_SIZE(K)) dut_b (
        .clk(clk), .rst(rst), .mode_avg(mode_avg), .s_valid(sv_b), .s_ready(rdy_b),
        .s_data(s_data), .m_valid(mv_b), .m_ready(m_ready), .m_data(md_b), .m_last(ml_b),
        .busy(busy_b)
    );

    // kind 0: channel c = pixel index + c; 1: random; 2: all 255
    task automatic fill(input int n, input int kind);
        for (int i = 0; i < n; i++)
            for (int c = 0; c < CH; c++)
                fr[i][c] = (kind == 0) ? i + c : (kind == 1) ? int'($urandom_range(0, 255)) : 255;
    endtask

    function automatic logic [CH*DW-1:0] pack(input int i);
        logic [CH*DW-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) v[c*DW +: DW] = DW'(fr[i][c]);
        return v;
    endfunction

    // Reference: pool each output window directly from the whole frame.
    task automatic build_exp(input int w, input int h, input bit avg);
        exp_q.delete();
        for (int oy = 0; oy < (h + K - 1) / K; oy++) begin
            for (int ox = 0; ox < (w + K - 1) / K; ox++) begin
                logic [CH*DW-1:0] v;
                v = '0;
                for (int c = 0; c < CH; c++) begin
                    int acc;
                    acc = 0;
                    for (int dy = 0; dy < K; dy++) begin
                        for (int dx = 0; dx < K; dx++) begin
                            int y, x;
                            y = oy * K + dy;
                            x = ox * K + dx;
                            if (y < h && x < w) begin
                                if (avg) acc = acc + fr[y*w+x][c];
                                else if (fr[y*w+x][c] > acc) acc = fr[y*w+x][c];
                            end
                        end
                    end
                    if (avg) acc = acc / (K * K);
                    v[c*DW +: DW] = DW'(acc);
                end
                exp_q.push_back(v);
            end
        end
    endtask

    task automatic run_frame(input logic s, input int w, input int h, input bit avg,
                             input bit rand_v, input bit rand_r, input bit stall,
                             input int flip_at, input string name);
        int n;
        bit model_avg;
        n = w * h;
`ifdef POOL_AVG_EN
        model_avg = avg;
`else
        model_avg = 1'b0;
`endif
        build_exp(w, h, model_avg);
        got_q.delete();
        got_last_q.delete();
        @(negedge clk);
        sel = s;
        mode_avg = avg;
        fork
            begin : drv
                int i, cyc;
                i = 0;
                cyc = 0;
                while (i < n && cyc < 2000) begin
                    @(negedge clk);
                    #1;
                    cyc++;
                    if (!s_valid && (!rand_v || $urandom_range(0, 2) != 0)) begin
                        s_valid = 1'b1;
                        s_data  = pack(i);
                        if (i == flip_at) mode_avg = ~mode_avg;
                    end
                    if (s_valid && s_ready) begin
                        @(posedge clk);
                        #1;
                        s_valid = 1'b0;
                        i++;
                    end
                end
                s_valid = 1'b0;
            end
            begin : mon
                int cyc, stall_left;
                bit stalled;
                logic [CH*DW-1:0] held;
                cyc = 0;
                stall_left = 0;
                stalled = 1'b0;
                held = '0;
                while (got_q.size() < exp_q.size() && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                    if (stall && !stalled && m_valid) begin
                        stalled = 1'b1;
                        stall_left = 10;
                        held = m_data;
                    end
                    if (stall_left > 0) m_ready = 1'b0;
                    else m_ready = rand_r ? ($urandom_range(0, 3) != 0) : 1'b1;
                    #1;
                    if (stall_left > 0) begin
                        stall_left--;
                        n_tests++;
                        if (m_data !== held || s_ready !== 1'b0 || m_valid !== 1'b1) begin
                            n_fail++;
                            $display("FAIL %s stall: m_data=%h s_ready=%b m_valid=%b, required m_data=%h s_ready=0 m_valid=1",
                                     name, m_data, s_ready, m_valid, held);
                        end
                    end
                    if (m_valid && m_ready) begin
                        got_q.push_back(m_data);
                        got_last_q.push_back(m_last);
                    end
                end
            end
        join
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s count: got %0d outputs, required %0d", name, got_q.size(),
                     exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_tests++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL %s data[%0d]: got %h, required %h", name, k, got_q[k], exp_q[k]);
            end
            n_tests++;
            if (got_last_q[k] !== 1'(k == exp_q.size() - 1)) begin
                n_fail++;
                $display("FAIL %s last[%0d]: got %b, required %b", name, k, got_last_q[k],
                         k == exp_q.size() - 1);
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after: busy=%b m_valid=%b, required 0 0", name, busy, m_valid);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            sel = 1'(s);
            #1;
            n_tests++;
            if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 || busy !== 1'b0 ||
                s_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset[%0d]: valid=%b data=%h last=%b busy=%b ready=%b, required 0 0 0 0 1",
                         s, m_valid, m_data, m_last, busy, s_ready);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_max_basic();
        fill(16, 0);
        run_frame(1'b0, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0, -1, "max4x4");
    endtask

    task automatic test_avg();
`ifdef POOL_AVG_EN
        fill(16, 0);
        run_frame(1'b0, 4, 4, 1'b1, 1'b0, 1'b0, 1'b0, -1, "avg4x4");
        fill(16, 2);
        run_frame(1'b0, 4, 4, 1'b1, 1'b0, 1'b0, 1'b0, -1, "avg255");
        fill(25, 1);
        run_frame(1'b1, 5, 5, 1'b1, 1'b0, 1'b0, 1'b0, -1, "avg5x5_pad");
`endif
    endtask

    task automatic test_ragged();
        fill(25, 0);
        run_frame(1'b1, 5, 5, 1'b0, 1'b0, 1'b0, 1'b0, -1, "max5x5");
    endtask

    task automatic test_backpressure();
        fill(16, 1);
        run_frame(1'b0, 4, 4, 1'b0, 1'b0, 1'b0, 1'b1, -1, "stall");
    endtask

    task automatic test_reset_midframe();
        int i, cyc;
        i = 0;
        cyc = 0;
        fill(16, 0);
        @(negedge clk);
        sel = 1'b0;
        mode_avg = 1'b0;
        m_ready = 1'b0;
        // With m_ready low the stream stalls once window (0,0) is output, after six beats.
        while (i < 6 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
            s_valid = 1'b1;
            s_data = pack(i);
            if (s_ready) begin
                @(posedge clk);
                #1;
                i++;
            end
        end
        s_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (m_valid !== 1'b1 || busy !== 1'b1 || i != 6) begin
            n_fail++;
            $display("FAIL pre_reset: m_valid=%b busy=%b beats=%0d, required 1 1 6", m_valid,
                     busy, i);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: m_valid=%b busy=%b m_data=%h, required 0 0 0", m_valid,
                     busy, m_data);
        end
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        run_frame(1'b0, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0, -1, "after_reset");
    endtask

    task automatic test_mode_flip();
        fill(16, 0);
        run_frame(1'b0, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0, 6, "flip_max");
        fill(25, 1);
        run_frame(1'b1, 5, 5, 1'b1, 1'b1, 1'b0, 1'b0, 9, "flip_avg");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            logic s;
            s = 1'(r % 2);
            fill(25, 1);
            run_frame(s, s ? 5 : 4, s ? 5 : 4, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, -1,
                      "random");
        end
    endtask

    initial begin
        test_reset();
        test_max_basic();
        test_avg();
        test_ragged();
        test_backpressure();
        test_reset_midframe();
        test_mode_flip();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
